// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline: stage-register state encodings
// and the default payload widths used by the CPU top.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;

endpackage

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register: valid/ready handshake with a 2-entry skid
// buffer (in_ready fully registered), synchronous flush and a stall counter.
module pipe_skid_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned        DATA_W    = PC_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int unsigned        CNT_W     = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              push, pop;

  // Handshake outputs decode only the state flop, never out_ready or in_valid.
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

  assign push = in_valid & in_ready & en & ~flush;
  assign pop  = out_valid & out_ready & en;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    if (en) begin
      if (flush) begin
        state_d = ST_EMPTY;
        main_d  = RESET_VAL;
        skid_d  = RESET_VAL;
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            if (push) begin
              state_d = ST_ONE;
              main_d  = in_data;
            end
          end
          ST_ONE: begin
            if (push && pop) begin
              main_d = in_data;
            end else if (push) begin
              state_d = ST_FULL;
              skid_d  = in_data;
            end else if (pop) begin
              state_d = ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (pop) begin
              state_d = ST_ONE;
              main_d  = skid_q;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end

      if (out_valid && !out_ready && (stall_q != '1)) begin
        stall_d = stall_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule
